// File: rtl/sram_sched_pkg.sv
// Shared widths, FSM states and the read-tag payload for the SRAM request scheduler.
package sram_sched_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 32;
  localparam int unsigned SRAM_MASK_W = 4;
  localparam int unsigned PORT_ID_W   = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAINING = 2'd1,
    ST_DRAINED  = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic                 valid;
    logic [PORT_ID_W-1:0] port;
  } tag_t;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Combinational round-robin picker: first eligible port strictly after the pointer, wrapping.
module sram_rr_arbiter #(
  parameter  int unsigned NUM_PORTS = 4,
  localparam int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] i_eligible,
  input  logic [IDX_W-1:0]     i_ptr,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [IDX_W-1:0]     o_grant_idx,
  output logic                 o_grant_any
);

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_any = 1'b0;
    w_idx       = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      w_idx = IDX_W'((32'(i_ptr) + k) % NUM_PORTS);
      if (!o_grant_any && i_eligible[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
        o_grant_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_request_scheduler.sv
// Shares one SRAM command port among NUM_PORTS requesters with round-robin grant,
// per-port read credits, a fixed-latency tag pipe for read routing, and drain control.
module sram_request_scheduler
  import sram_sched_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned READ_LATENCY = 3,
  parameter int unsigned READ_CREDITS = 4
) (
  input  logic                             sram_clock,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [SRAM_MASK_W*NUM_PORTS-1:0] req_mask,
  input  logic [SRAM_ADDR_W*NUM_PORTS-1:0] req_addr,
  input  logic [SRAM_DATA_W*NUM_PORTS-1:0] req_data,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [SRAM_DATA_W-1:0]           rsp_data,
  input  logic [NUM_PORTS-1:0]             credit_return,
  input  logic                             drain,
  output logic                             idle,
  output logic                             sram_addr_valid,
  input  logic                             sram_ready,
  output logic [SRAM_ADDR_W-1:0]           sram_addr,
  output logic [SRAM_DATA_W-1:0]           sram_data_in,
  output logic [SRAM_MASK_W-1:0]           sram_write_mask,
  input  logic [SRAM_DATA_W-1:0]           sram_data_out,
  input  logic                             sram_data_out_valid,
  output logic                             err_unexpected,
  output logic                             err_missing
);

  localparam int unsigned IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CRED_W = $clog2(READ_CREDITS + 1);

  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  sched_state_e           r_state;
  logic                   r_idle;
  logic [CRED_W-1:0]      r_credit [NUM_PORTS];
  logic [IDX_W-1:0]       r_rr_ptr;
  logic                   r_sram_addr_valid;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [SRAM_DATA_W-1:0] r_sram_data_in;
  logic [SRAM_MASK_W-1:0] r_sram_write_mask;
  logic [PORT_ID_W-1:0]   r_cmd_port;
  tag_t                   r_tag [READ_LATENCY];
  logic [NUM_PORTS-1:0]   r_rsp_valid;
  logic [SRAM_DATA_W-1:0] r_rsp_data;
  logic                   r_err_unexpected;
  logic                   r_err_missing;

  logic [NUM_PORTS-1:0]   w_eligible;
  logic [NUM_PORTS-1:0]   w_grant;
  logic [IDX_W-1:0]       w_grant_idx;
  logic                   w_grant_any;
  logic                   w_grant_en;
  logic                   w_sel_write;
  logic [SRAM_MASK_W-1:0] w_sel_mask;
  logic                   w_issue;
  logic                   w_push;
  tag_t                   w_tag_due;
  logic                   w_rsp_load;
  logic                   w_tags_busy;
  logic                   w_empty;

  // Async assert, sync release of the internal reset.
  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_comb begin
    w_eligible = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++)
      w_eligible[p] = req_valid[p] & (req_write[p] | (r_credit[p] != '0));
  end

  assign w_grant_en = w_rst_n & (r_state == ST_RUN) & (!r_sram_addr_valid | sram_ready);

  sram_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .i_eligible  (w_eligible & {NUM_PORTS{w_grant_en}}),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_any (w_grant_any)
  );

  assign req_ready   = w_grant;
  assign w_sel_write = req_write[w_grant_idx];
  assign w_sel_mask  = req_mask[32'(w_grant_idx)*SRAM_MASK_W +: SRAM_MASK_W];
  assign w_issue     = !w_sel_write | (w_sel_mask != '0);

  // Command register; a zero-mask write is consumed without reaching the SRAM.
  always_ff @(posedge sram_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sram_addr_valid <= 1'b0;
      r_sram_addr       <= '0;
      r_sram_data_in    <= '0;
      r_sram_write_mask <= '0;
      r_cmd_port        <= '0;
      r_rr_ptr          <= IDX_W'(NUM_PORTS - 1);
    end else begin
      if (w_grant_any) r_rr_ptr <= w_grant_idx;
      if (w_grant_any && w_issue) begin
        r_sram_addr_valid <= 1'b1;
        r_sram_addr       <= req_addr[32'(w_grant_idx)*SRAM_ADDR_W +: SRAM_ADDR_W];
        r_sram_data_in    <= req_data[32'(w_grant_idx)*SRAM_DATA_W +: SRAM_DATA_W];
        r_sram_write_mask <= w_sel_write ? w_sel_mask : '0;
        r_cmd_port        <= PORT_ID_W'(w_grant_idx);
      end else if (sram_ready) begin
        r_sram_addr_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge sram_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) r_credit[p] <= CRED_W'(READ_CREDITS);
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (w_grant[p] && !req_write[p] && !credit_return[p])
          r_credit[p] <= r_credit[p] - CRED_W'(1);
        else if (!(w_grant[p] && !req_write[p]) && credit_return[p] &&
                 (r_credit[p] != CRED_W'(READ_CREDITS)))
          r_credit[p] <= r_credit[p] + CRED_W'(1);
      end
    end
  end

  assign w_push     = r_sram_addr_valid & sram_ready & (r_sram_write_mask == '0);
  assign w_tag_due  = r_tag[READ_LATENCY-1];
  assign w_rsp_load = w_tag_due.valid & sram_data_out_valid;

  always_comb begin
    w_tags_busy = 1'b0;
    for (int unsigned i = 0; i < READ_LATENCY; i++) w_tags_busy = w_tags_busy | r_tag[i].valid;
  end

  always_ff @(posedge sram_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_push ? tag_t'{valid: 1'b1, port: r_cmd_port} : '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Response stage: data is paired with the tag that falls due this cycle.
  always_ff @(posedge sram_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rsp_valid      <= '0;
      r_rsp_data       <= '0;
      r_err_unexpected <= 1'b0;
      r_err_missing    <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (w_rsp_load) begin
        r_rsp_valid <= NUM_PORTS'(1) << w_tag_due.port;
        r_rsp_data  <= sram_data_out;
      end
      if (sram_data_out_valid && !w_tag_due.valid) r_err_unexpected <= 1'b1;
      if (w_tag_due.valid && !sram_data_out_valid) r_err_missing    <= 1'b1;
    end
  end

  // Pipeline counts as empty once no response will be loaded into the output stage.
  assign w_empty = !r_sram_addr_valid & !w_tags_busy & !w_rsp_load;

  always_ff @(posedge sram_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_RUN;
      r_idle  <= 1'b0;
    end else begin
      r_idle <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (drain) r_state <= ST_DRAINING;
        end
        ST_DRAINING: begin
          if (!drain) begin
            r_state <= ST_RUN;
          end else if (w_empty) begin
            r_state <= ST_DRAINED;
            r_idle  <= 1'b1;
          end
        end
        ST_DRAINED: begin
          if (!drain) r_state <= ST_RUN;
          else        r_idle  <= 1'b1;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign idle            = r_idle;
  assign sram_addr_valid = r_sram_addr_valid;
  assign sram_addr       = r_sram_addr;
  assign sram_data_in    = r_sram_data_in;
  assign sram_write_mask = r_sram_write_mask;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;
  assign err_unexpected  = r_err_unexpected;
  assign err_missing     = r_err_missing;

endmodule
